// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings and FSM states.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'd0;
  localparam logic [1:0] OP_MULT  = 2'd1;
  localparam logic [1:0] OP_DIVU  = 2'd2;
  localparam logic [1:0] OP_DIV   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX
  } state_t;

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// Conditional two's-complement negation: o_y = i_neg ? -i_x : i_x.
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_neg ? ({WIDTH{1'b0}} - i_x) : i_x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers
// and a start/busy/done handshake for the pipeline control.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  state_t r_state;
  state_t w_next;

  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_signA;
  logic               r_signB;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_divZero;

  logic               w_isSigned;
  logic               w_isDiv;
  logic               w_accept;
  logic               w_negA;
  logic               w_negB;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [WIDTH:0]     w_mulSum;
  logic [WIDTH:0]     w_divShift;
  logic               w_divGe;
  logic [WIDTH:0]     w_divRem;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_fixIn;
  logic [2*WIDTH-1:0] w_fixOut;
  logic               w_fixNeg;
  logic               w_remNeg;
  logic [WIDTH-1:0]   w_remOut;
  logic               w_bZero;

  assign w_isSigned = (r_op == OP_MULT) || (r_op == OP_DIV);
  assign w_isDiv    = (r_op == OP_DIVU) || (r_op == OP_DIV);
  assign w_accept   = (r_state == S_IDLE) && start && !flush;
  assign w_negA     = w_isSigned & r_a[WIDTH-1];
  assign w_negB     = w_isSigned & r_b[WIDTH-1];

  cond_negate #(.WIDTH(WIDTH)) u_magA (.i_x(r_a), .i_neg(w_negA), .o_y(w_magA));
  cond_negate #(.WIDTH(WIDTH)) u_magB (.i_x(r_b), .i_neg(w_negB), .o_y(w_magB));

  // r_acc holds {partial product, multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide.
  assign w_mulSum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_divShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_divGe    = (w_divShift >= {1'b0, r_opnd});
  assign w_divRem   = w_divGe ? (w_divShift - {1'b0, r_opnd}) : w_divShift;
  assign w_step     = w_isDiv ? {w_divRem[WIDTH-1:0], r_acc[WIDTH-2:0], w_divGe}
                              : {w_mulSum, r_acc[WIDTH-1:1]};

  assign w_fixIn  = w_isDiv ? {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]} : r_acc;
  assign w_fixNeg = w_isSigned & (r_signA ^ r_signB);
  assign w_remNeg = w_isSigned & r_signA;
  assign w_bZero  = w_isDiv && (r_b == {WIDTH{1'b0}});

  cond_negate #(.WIDTH(2*WIDTH)) u_fixProd (.i_x(w_fixIn), .i_neg(w_fixNeg), .o_y(w_fixOut));
  cond_negate #(.WIDTH(WIDTH)) u_fixRem (.i_x(r_acc[2*WIDTH-1:WIDTH]), .i_neg(w_remNeg), .o_y(w_remOut));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // flush overrides everything, including a start in IDLE.
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next = S_PREP;
        S_PREP:  w_next = S_RUN;
        S_RUN:   if (r_cnt == CNT_W'(1)) w_next = S_FIX;
        S_FIX:   w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= 2'd0;
      r_a       <= '0;
      r_b       <= '0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_signA   <= 1'b0;
      r_signB   <= 1'b0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_divZero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (w_accept) begin
            r_op      <= op;
            r_a       <= a;
            r_b       <= b;
            r_divZero <= 1'b0;
          end
        end
        S_PREP: if (!flush) begin
          r_signA <= w_negA;
          r_signB <= w_negB;
          r_opnd  <= w_isDiv ? w_magB : w_magA;
          r_acc   <= {{WIDTH{1'b0}}, (w_isDiv ? w_magA : w_magB)};
          r_cnt   <= CNT_INIT;
        end
        S_RUN: if (!flush) begin
          r_acc <= w_step;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_FIX: if (!flush) begin
          r_done <= 1'b1;
          if (w_bZero) begin
            r_hi      <= r_a;
            r_lo      <= '1;
            r_divZero <= 1'b1;
          end else if (w_isDiv) begin
            r_hi <= w_remOut;
            r_lo <= w_fixOut[WIDTH-1:0];
          end else begin
            r_hi <= w_fixOut[2*WIDTH-1:WIDTH];
            r_lo <= w_fixOut[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign div_zero = r_divZero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed results.
module tb_muldiv_unit;

  localparam logic [1:0] MULTU = 2'd0;
  localparam logic [1:0] MULT  = 2'd1;
  localparam logic [1:0] DIVU  = 2'd2;
  localparam logic [1:0] DIV   = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int tStart   = 0;
  int lat;
  int busyCnt;
  int doneSeen;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic startOp(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb);
    @(negedge clk);
    op = o; a = aa; b = bb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    tStart = cyc;
  endtask

  task automatic waitDone(output int latency, output int busyCycles);
    busyCycles = 0;
    @(negedge clk);
    while (!done && (cyc - tStart) < 200) begin
      if (busy) busyCycles++;
      @(negedge clk);
    end
    latency = cyc - tStart;
    if (!done) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                               output int latency, output int busyCycles);
    startOp(o, aa, bb);
    waitDone(latency, busyCycles);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'd0; a = '0; b = '0; wdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_dz", {31'd0, div_zero}, 32'd0);
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    rst_n = 1'b1;

    applyStimulus(MULTU, 32'h0000CE42, 32'h00005EFB, lat, busyCnt);
    checkOutput("multu_lat", lat, 32'd34);
    checkOutput("multu_busy", busyCnt, 32'd34);
    checkOutput("multu_hi", hi, 32'h00000000);
    checkOutput("multu_lo", lo, 32'h4C8676B6);
    @(negedge clk);
    checkOutput("done_pulse", {31'd0, done}, 32'd0);

    applyStimulus(MULT, 32'hFFFFFFFF, 32'h00000002, lat, busyCnt);
    checkOutput("mult_hi", hi, 32'hFFFFFFFF);
    checkOutput("mult_lo", lo, 32'hFFFFFFFE);

    applyStimulus(DIV, 32'hFFFFFFF9, 32'h00000002, lat, busyCnt);
    checkOutput("div_lo", lo, 32'hFFFFFFFD);
    checkOutput("div_hi", hi, 32'hFFFFFFFF);

    applyStimulus(DIVU, 32'h0000A759, 32'h000056E0, lat, busyCnt);
    checkOutput("divu_lo", lo, 32'h00000001);
    checkOutput("divu_hi", hi, 32'h00005079);
    checkOutput("divu_dz", {31'd0, div_zero}, 32'd0);

    applyStimulus(DIVU, 32'h0000A759, 32'h00000000, lat, busyCnt);
    checkOutput("dz_lat", lat, 32'd34);
    checkOutput("dz_lo", lo, 32'hFFFFFFFF);
    checkOutput("dz_hi", hi, 32'h0000A759);
    checkOutput("dz_flag", {31'd0, div_zero}, 32'd1);

    // start together with flush in IDLE must not be accepted
    @(negedge clk);
    op = MULTU; a = 32'd1; b = 32'd1; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checkOutput("startflush_busy", {31'd0, busy}, 32'd0);
    checkOutput("startflush_dz", {31'd0, div_zero}, 32'd1);

    applyStimulus(MULTU, 32'd3, 32'd5, lat, busyCnt);
    checkOutput("dz_clear", {31'd0, div_zero}, 32'd0);
    checkOutput("multu2_lo", lo, 32'd15);

    applyStimulus(DIV, 32'h80000000, 32'hFFFFFFFF, lat, busyCnt);
    checkOutput("ovf_lo", lo, 32'h80000000);
    checkOutput("ovf_hi", hi, 32'h00000000);

    // MTHI and a second start while busy are both ignored
    startOp(MULTU, 32'd3, 32'd4);
    repeat (3) @(negedge clk);
    op = DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    hi_we = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    checkOutput("busy_mthi_hi", hi, 32'h00000000);
    checkOutput("busy_still", {31'd0, busy}, 32'd1);
    waitDone(lat, busyCnt);
    checkOutput("restart_lat", lat, 32'd34);
    checkOutput("restart_lo", lo, 32'd12);
    checkOutput("restart_hi", hi, 32'd0);

    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    hi_we = 1'b0;
    checkOutput("mthi_idle", hi, 32'h12345678);

    // flush in the middle of RUN
    startOp(MULTU, 32'h0000FFFF, 32'h0000FFFF);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy", {31'd0, busy}, 32'd0);
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("flush_nodone", doneSeen, 32'd0);
    checkOutput("flush_hi", hi, 32'h12345678);
    checkOutput("flush_lo", lo, 32'd12);

    // asynchronous reset mid-RUN
    startOp(MULTU, 32'h00001234, 32'h00000010);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_done", {31'd0, done}, 32'd0);
    checkOutput("arst_dz", {31'd0, div_zero}, 32'd0);
    checkOutput("arst_hi", hi, 32'd0);
    checkOutput("arst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(MULTU, 32'd6, 32'd7, lat, busyCnt);
    checkOutput("post_rst_lat", lat, 32'd34);
    checkOutput("post_rst_lo", lo, 32'd42);
    checkOutput("post_rst_hi", hi, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath; the sequential companion to the combinational ALU.
- Executes MULT, MULTU, DIV and DIVU on WIDTH-bit operands over multiple cycles.
- Writes results into architectural HI/LO registers and exposes them for MFHI/MFLO.
- Uses a start/busy/done handshake so the control unit can stall while an operation runs.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  2  0=MULTU, 1=MULT, 2=DIVU, 3=DIV.
- a  in  WIDTH  multiplicand or dividend (rs).
- b  in  WIDTH  multiplier or divisor (rt).
- flush  in  1  synchronous abort, return to IDLE.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when HI/LO are updated.
- div_zero  out  1  sticky flag: last divide had b==0; cleared at the next accepted start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; internal counter and accumulators cleared.
- Acceptance: start=1 in IDLE at edge k latches op, a and b.
- Signed ops (MULT, DIV): store operand magnitudes plus sign flags. Unsigned ops: store operands unchanged.
- Timing: busy=1 from edge k until the edge at which done rises. done=1 for exactly the cycle after edge k+WIDTH+2, and hi/lo update on that same edge. Total latency is therefore WIDTH+2 cycles.
- States:
  - IDLE: wait for start.
  - PREP: one cycle; conditionally negate the operands and clear the accumulator.
  - RUN: WIDTH cycles, counter counts down.
  - FIX: one cycle; sign correction and HI/LO write.
  - FIX -> IDLE, with done asserted.
- Multiply: shift-add, one multiplier bit per RUN cycle, into a 2*WIDTH product. For MULT, negate the product if sign_a^sign_b. Result: hi = upper WIDTH bits, lo = lower WIDTH bits.
- Divide: restoring, one quotient bit per RUN cycle. Result: lo = quotient, hi = remainder.
  - DIV: negate the quotient if sign_a^sign_b; the remainder takes the sign of the dividend.
  - DIV overflow (MIN / -1): lo = MIN, hi = 0. No flag.
- Divide by zero (b==0 on DIVU or DIV): same latency. Result is lo = all ones, hi = a unchanged, div_zero = 1.
- start while busy: ignored, no queuing.
- start and flush in the same IDLE cycle: flush wins and the start is not accepted.
- flush in PREP/RUN/FIX: next state is IDLE. busy=0 next cycle, no done pulse, hi/lo unchanged, div_zero unchanged.
- hi_we/lo_we: applied only in IDLE, taking effect on the next edge; ignored while busy. If an MTHI/MTLO write arrives in the same IDLE cycle as an accepted start, the write still happens, and the later FIX writes overwrite it.
- hi and lo are direct register outputs with no combinational path from the inputs.
- Reset asserted mid-operation: immediate return to the reset values above.

Decomposition:
- muldiv_pkg holds:
  - op encodings: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV.
  - state enum: S_IDLE, S_PREP, S_RUN, S_FIX.
- One sub-module, cond_negate(WIDTH): output = neg ? -x : x.
  - Instantiate it for operand magnitudes in PREP.
  - Instantiate it (2*WIDTH wide) for product/quotient/remainder correction in FIX.
- Shift-add and restoring step logic stay inline in the FSM.

Test Plan:
- MULTU, a=0x0000CE42, b=0x00005EFB -> done exactly 34 cycles after start; hi=0x00000000, lo=0x4C8676B6; busy high 34 cycles.
- MULT, a=0xFFFFFFFF, b=0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. DIV, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU, a=0x0000A759, b=0x000056E0 -> lo=0x00000001, hi=0x00005079, div_zero=0. Then DIVU a=0x0000A759, b=0 -> lo=0xFFFFFFFF, hi=0x0000A759, div_zero=1. The next MULTU start clears div_zero.
- DIV, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000. Then MTHI wdata=0x12345678 while busy -> ignored; MTHI in IDLE -> hi=0x12345678 next cycle.
- Start a MULTU, pulse flush at RUN cycle 10 -> busy=0 next cycle, no done, hi/lo keep prior values. A second start asserted mid-operation is ignored.
- Assert rst_n=0 asynchronously mid-RUN -> busy, done, hi, lo and div_zero go to 0 immediately. A new start after rst_n release completes normally.
